// File: rtl/decode_2_4_hs_if.sv
// Handshake bundle for the one-hot decoder: {Y,V} words in, decoded D out.
// master drives the upstream word and downstream ready; slave is the decoder.
interface decode_2_4_hs_if #(
  parameter int W = 2
);
  localparam int N = 1 << W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Y;
  logic         V;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] D;

  modport master (
    output in_valid, Y, V, out_ready,
    input  in_ready, out_valid, D
  );

  modport slave (
    input  in_valid, Y, V, out_ready,
    output in_ready, out_valid, D
  );
endinterface

// File: rtl/decode_2_4_hs.sv
// Handshaked W-to-2^W one-hot decoder behind a 2-entry elastic buffer,
// with a per-line sticky hit register fed by popped words.

// One decoded line: sticky hit bit, a hit-setting pop wins over clear.
module decode_2_4_hs_line (
  input  logic clk,
  input  logic rst_n,
  input  logic sel,
  input  logic pop,
  input  logic hit_clr,
  output logic hit
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            hit <= 1'b0;
    else if (pop && sel)   hit <= 1'b1;
    else if (hit_clr)      hit <= 1'b0;
  end
endmodule

module decode_2_4_hs #(
  parameter int W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  decode_2_4_hs_if.slave      bus,
  input  logic                hit_clr,
  output logic [(1<<W)-1:0]   hit
);
  localparam int N = 1 << W;

  typedef struct packed {
    logic         v;
    logic [W-1:0] y;
  } word_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} cnt_e;

  cnt_e         state, state_nxt;
  word_t        mem [2];
  word_t        head;
  word_t        wr_word;
  logic         wptr, rptr;
  logic         in_ready, out_valid;
  logic         push, pop;
  logic [N-1:0] d;

  assign wr_word = '{v: bus.V, y: bus.Y};
  assign head    = mem[rptr];

  // Handshake flags depend on occupancy only, so no comb path in->out.
  always_comb begin
    state_nxt = state;
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    push      = bus.in_valid && in_ready;
    pop       = out_valid && bus.out_ready;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (!push && pop) state_nxt = EMPTY;
      end
      FULL:  if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_word;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
    end
  end

  always_comb begin
    d = '0;
    if (out_valid && head.v) d = {{(N-1){1'b0}}, 1'b1} << head.y;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.D         = d;

  for (genvar i = 0; i < N; i++) begin : g_line
    decode_2_4_hs_line u_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .sel     (d[i]),
      .pop     (pop),
      .hit_clr (hit_clr),
      .hit     (hit[i])
    );
  end
endmodule

// File: tb/tb_decode_2_4_hs.sv
// Directed and queue-model checks for the handshaked one-hot decoder.
module tb_decode_2_4_hs;
  logic       clk;
  logic       rst_n;
  logic       hit_clr;
  logic [3:0] hit;
  int         checks;
  int         errors;

  decode_2_4_hs_if #(.W(2)) bus ();

  decode_2_4_hs #(.W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .hit_clr (hit_clr),
    .hit     (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic v, input logic [1:0] y, input logic ordy);
    bus.in_valid  = iv;
    bus.V         = v;
    bus.Y         = y;
    bus.out_ready = ordy;
  endtask

  function automatic logic [3:0] dec(input logic v, input logic [1:0] y);
    logic [3:0] r;
    r = 4'b0000;
    if (v) r[y] = 1'b1;
    return r;
  endfunction

  initial begin
    logic [2:0] q[$];
    logic [3:0] hit_m;
    logic       iv, ordy, vv, clr, do_push, do_pop;
    logic [1:0] yy;
    logic [2:0] fr;

    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    hit_clr = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    #2;
    chk("rst_out_valid", {3'b0, bus.out_valid}, 4'b0000);
    chk("rst_in_ready",  {3'b0, bus.in_ready},  4'b0001);
    chk("rst_D",   bus.D, 4'b0000);
    chk("rst_hit", hit,   4'b0000);
    step();
    rst_n = 1'b1;

    // T1: preload hit, fill to FULL, then reset asynchronously mid-cycle
    drive(1'b1, 1'b1, 2'd3, 1'b1);
    step();
    chk("t1_first_D", bus.D, 4'b1000);
    drive(1'b0, 1'b0, 2'd0, 1'b1);
    step();
    chk("t1_hit_pre", hit, 4'b1000);
    drive(1'b1, 1'b1, 2'd1, 1'b0);
    step();
    drive(1'b1, 1'b1, 2'd2, 1'b0);
    step();
    chk("t1_full_in_ready", {3'b0, bus.in_ready}, 4'b0000);
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid", {3'b0, bus.out_valid}, 4'b0000);
    chk("t1_D",   bus.D, 4'b0000);
    chk("t1_hit", hit,   4'b0000);
    chk("t1_in_ready", {3'b0, bus.in_ready}, 4'b0001);
    step();
    rst_n = 1'b1;

    // T2: decode sweep at full rate
    drive(1'b1, 1'b1, 2'd0, 1'b1);
    step();
    chk("t2_D0", bus.D, 4'b0001);
    drive(1'b1, 1'b1, 2'd1, 1'b1);
    step();
    chk("t2_D1", bus.D, 4'b0010);
    drive(1'b1, 1'b1, 2'd2, 1'b1);
    step();
    chk("t2_D2", bus.D, 4'b0100);
    drive(1'b1, 1'b1, 2'd3, 1'b1);
    step();
    chk("t2_D3", bus.D, 4'b1000);
    drive(1'b0, 1'b0, 2'd0, 1'b1);
    step();
    chk("t2_hit", hit, 4'b1111);
    chk("t2_empty", {3'b0, bus.out_valid}, 4'b0000);

    // T3: V=0 word decodes to nothing and leaves hit alone
    drive(1'b1, 1'b0, 2'd2, 1'b0);
    step();
    chk("t3_out_valid", {3'b0, bus.out_valid}, 4'b0001);
    chk("t3_D", bus.D, 4'b0000);
    drive(1'b0, 1'b0, 2'd0, 1'b1);
    step();
    chk("t3_hit", hit, 4'b1111);
    chk("t3_empty", {3'b0, bus.out_valid}, 4'b0000);

    // T4: backpressure
    drive(1'b1, 1'b1, 2'd1, 1'b0);
    step();
    chk("t4_D_a", bus.D, 4'b0010);
    chk("t4_in_ready_a", {3'b0, bus.in_ready}, 4'b0001);
    drive(1'b1, 1'b1, 2'd3, 1'b0);
    step();
    chk("t4_in_ready_full", {3'b0, bus.in_ready}, 4'b0000);
    chk("t4_D_b", bus.D, 4'b0010);
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    step();
    chk("t4_D_hold", bus.D, 4'b0010);
    drive(1'b0, 1'b0, 2'd0, 1'b1);
    step();
    chk("t4_D_next", bus.D, 4'b1000);
    chk("t4_in_ready_b", {3'b0, bus.in_ready}, 4'b0001);
    step();
    chk("t4_empty", {3'b0, bus.out_valid}, 4'b0000);

    // T6: clear alone, then clear racing a hit-setting pop
    hit_clr = 1'b1;
    step();
    hit_clr = 1'b0;
    chk("t6_clr_a", hit, 4'b0000);
    drive(1'b1, 1'b1, 2'd0, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'd0, 1'b1);
    step();
    chk("t6_hit_set", hit, 4'b0001);
    drive(1'b1, 1'b1, 2'd2, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'd0, 1'b1);
    hit_clr = 1'b1;
    step();
    chk("t6_set_wins", hit, 4'b0100);
    step();
    hit_clr = 1'b0;
    chk("t6_clr_b", hit, 4'b0000);

    // T5: random traffic against a reference queue
    hit_m = 4'b0000;
    for (int n = 0; n < 100; n++) begin
      iv   = ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      vv   = ($urandom_range(4) != 0);
      yy   = 2'($urandom_range(3));
      clr  = ($urandom_range(9) == 0);
      drive(iv, vv, yy, ordy);
      hit_clr = clr;
      fr = (q.size() != 0) ? q[0] : 3'b000;
      chk("t5_in_ready",  {3'b0, bus.in_ready},  {3'b0, q.size() < 2});
      chk("t5_out_valid", {3'b0, bus.out_valid}, {3'b0, q.size() != 0});
      chk("t5_D", bus.D, (q.size() != 0) ? dec(fr[2], fr[1:0]) : 4'b0000);
      do_push = iv && (q.size() < 2);
      do_pop  = ordy && (q.size() != 0);
      if (do_pop && fr[2])
        hit_m = clr ? dec(1'b1, fr[1:0]) : (hit_m | dec(1'b1, fr[1:0]));
      else if (clr)
        hit_m = 4'b0000;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({vv, yy});
      step();
      chk("t5_hit", hit, hit_m);
    end
    hit_clr = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b1);
    step();
    step();
    chk("t5_drained", {3'b0, bus.out_valid}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
